comp_seq: RTL and testbench

- Fetch/execute sequencer for the 32-entry, 16-bit-word program datapath.
- Walks a program counter over instruction memory through a valid-handshake read port.
- Decodes op = word[15:8] and imm = word[7:0], runs a small 8-bit accumulator ISA, and drives the 16-bit result output.
- Sits between the instruction store and the output register stage, replacing free-running counter fetch with a controlled start/run/halt sequence.

---
 rtl/comp_seq.sv | 151 +++++++++++++++
 tb/tb_comp_seq.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/comp_seq.sv
// Fetch/execute sequencer: fetches 16-bit instructions over a valid-handshake port
// and runs a small 8-bit accumulator ISA, publishing results on out/out_valid.
module comp_seq #(
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned START_PC = 0,
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_rvalid,
  input  logic [15:0]       mem_rdata,
  output logic [15:0]       out,
  output logic              out_valid,
  output logic              busy,
  output logic              halted,
  output logic              err,
  output logic [ADDR_W-1:0] pc
);

  localparam int unsigned WAIT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);
  localparam logic [ADDR_W-1:0] PC_INIT   = ADDR_W'(START_PC);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    EXEC,
    HALT
  } state_t;

  typedef enum logic [7:0] {
    OP_NOP  = 8'h00,
    OP_OUTI = 8'h01,
    OP_LDI  = 8'h02,
    OP_ADDI = 8'h03,
    OP_OUTA = 8'h04,
    OP_JMP  = 8'h05,
    OP_JZ   = 8'h06,
    OP_HALT = 8'hFF
  } op_t;

  state_t              state;
  state_t              next_state;
  logic [15:0]         ir;
  logic [7:0]          acc;
  logic [WAIT_W-1:0]   wait_cnt;
  logic [7:0]          op;
  logic [7:0]          imm;

  assign op  = ir[15:8];
  assign imm = ir[7:0];

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE, HALT: if (start) next_state = FETCH;
      FETCH: begin
        if (mem_rvalid)                next_state = EXEC;
        else if (wait_cnt == WAIT_LAST) next_state = HALT;
      end
      EXEC: begin
        case (op)
          OP_NOP, OP_OUTI, OP_LDI, OP_ADDI,
          OP_OUTA, OP_JMP, OP_JZ:      next_state = FETCH;
          default:                     next_state = HALT;
        endcase
      end
    endcase
  end

  always_comb begin
    mem_req  = (state == FETCH);
    mem_addr = pc;
    busy     = (state == FETCH) || (state == EXEC);
    halted   = (state == HALT);
  end

  // The wait counter is cleared on every path into FETCH, so each fetch
  // gets its own full MAX_WAIT budget.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc        <= PC_INIT;
      acc       <= '0;
      ir        <= '0;
      out       <= '0;
      out_valid <= 1'b0;
      err       <= 1'b0;
      wait_cnt  <= '0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE, HALT: begin
          if (start) begin
            pc       <= PC_INIT;
            acc      <= '0;
            err      <= 1'b0;
            wait_cnt <= '0;
          end
        end
        FETCH: begin
          if (mem_rvalid) begin
            ir       <= mem_rdata;
            wait_cnt <= '0;
          end else if (wait_cnt == WAIT_LAST) begin
            err <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        EXEC: begin
          wait_cnt <= '0;
          case (op)
            OP_NOP:  pc <= pc + ADDR_W'(1);
            OP_OUTI: begin
              out       <= {8'd0, imm};
              out_valid <= 1'b1;
              pc        <= pc + ADDR_W'(1);
            end
            OP_LDI: begin
              acc <= imm;
              pc  <= pc + ADDR_W'(1);
            end
            OP_ADDI: begin
              acc <= acc + imm;
              pc  <= pc + ADDR_W'(1);
            end
            OP_OUTA: begin
              out       <= {8'd0, acc};
              out_valid <= 1'b1;
              pc        <= pc + ADDR_W'(1);
            end
            OP_JMP:  pc <= imm[ADDR_W-1:0];
            OP_JZ:   pc <= (acc == 8'd0) ? imm[ADDR_W-1:0] : pc + ADDR_W'(1);
            OP_HALT: ;
            default: err <= 1'b1;
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_comp_seq.sv
// Scoreboard bench for comp_seq: an ISA interpreter predicts fetch addresses and
// output values; a monitor checks them as the DUT produces them.
module tb_comp_seq;
  localparam int DEPTH = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        mem_req;
  logic [4:0]  mem_addr;
  logic        mem_rvalid;
  logic [15:0] mem_rdata;
  logic [15:0] out;
  logic        out_valid;
  logic        busy;
  logic        halted;
  logic        err;
  logic [4:0]  pc;

  comp_seq #(.ADDR_W(5), .START_PC(0), .MAX_WAIT(15)) dut (
    .clk(clk), .rst(rst), .start(start),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .out(out), .out_valid(out_valid), .busy(busy), .halted(halted), .err(err), .pc(pc)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int exp_fetch[$];
  int exp_out[$];
  logic [15:0] tb_mem [DEPTH];
  int lat = 0;
  bit rand_lat = 0, no_resp = 0, force_rv = 0, allow_extra = 0;
  int m_pc;
  bit m_done, m_err;
  int drv_wcnt = 0, drv_lat = 0;
  logic prev_wait = 1'b0;
  logic [4:0] prev_addr = '0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, want, $time);
    end
  endtask

  // Instruction-level interpreter of the ISA.
  task automatic model_run(input int steps);
    int p, acc, imm;
    logic [15:0] w;
    logic [7:0] op;
    p = 0; acc = 0; m_done = 0; m_err = 0;
    for (int s = 0; s < steps && !m_done; s++) begin
      exp_fetch.push_back(p);
      w = tb_mem[p];
      op = w[15:8];
      imm = int'(w[7:0]);
      case (op)
        8'h00: p = (p + 1) % DEPTH;
        8'h01: begin exp_out.push_back(imm); p = (p + 1) % DEPTH; end
        8'h02: begin acc = imm; p = (p + 1) % DEPTH; end
        8'h03: begin acc = (acc + imm) % 256; p = (p + 1) % DEPTH; end
        8'h04: begin exp_out.push_back(acc); p = (p + 1) % DEPTH; end
        8'h05: p = imm % DEPTH;
        8'h06: p = (acc == 0) ? imm % DEPTH : (p + 1) % DEPTH;
        8'hFF: m_done = 1;
        default: begin m_done = 1; m_err = 1; end
      endcase
    end
    m_pc = p;
  endtask

  // Memory responder: answers a fetch after a configurable number of wait cycles.
  initial begin
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    forever begin
      @(negedge clk);
      if (force_rv) begin
        mem_rvalid = 1'b1; mem_rdata = 16'hFF00; drv_wcnt = 0;
      end else if (mem_req && !no_resp) begin
        if (drv_wcnt == 0) drv_lat = rand_lat ? int'($urandom_range(0, 3)) : lat;
        if (drv_wcnt >= drv_lat) begin
          mem_rvalid = 1'b1; mem_rdata = tb_mem[mem_addr]; drv_wcnt = 0;
        end else begin
          mem_rvalid = 1'b0; mem_rdata = 16'hDEAD; drv_wcnt++;
        end
      end else begin
        mem_rvalid = 1'b0; drv_wcnt = 0;
      end
    end
  end

  // Monitor: pops expectations whenever the DUT presents a fetch or a result.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (out_valid) begin
        if (exp_out.size() > 0) chk("out_value", 32'(out), exp_out.pop_front());
        else if (!allow_extra)  chk("unexpected_out_valid", 32'(out_valid), 32'd0);
      end
      if (mem_req && mem_rvalid) begin
        if (exp_fetch.size() > 0) chk("fetch_addr", 32'(mem_addr), exp_fetch.pop_front());
        else if (!allow_extra)    chk("unexpected_fetch", 32'(mem_req), 32'd0);
      end
      if (mem_req && prev_wait) chk("addr_stable", 32'(mem_addr), 32'(prev_addr));
      prev_wait = mem_req && !mem_rvalid;
      prev_addr = mem_addr;
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_fetch.delete();
    exp_out.delete();
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_halt(input int maxc);
    int n = 0;
    while (!halted && n < maxc) begin step(); n++; end
    chk("halt_timeout", 32'(halted), 32'd1);
  endtask

  task automatic wait_drain(input int maxc);
    int n = 0;
    while (exp_fetch.size() > 0 && n < maxc) begin step(); n++; end
    chk("drain_timeout", 32'(exp_fetch.size()), 32'd0);
  endtask

  task automatic load_prog1();
    for (int i = 0; i < DEPTH; i++) tb_mem[i] = 16'h0000;
    tb_mem[0] = 16'h0205; tb_mem[1] = 16'h0303;
    tb_mem[2] = 16'h0400; tb_mem[3] = 16'hFF00;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_out"}, 32'(out), 32'd0);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_mem_req"}, 32'(mem_req), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_halted"}, 32'(halted), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
    chk({tag, "_pc"}, 32'(pc), 32'd0);
  endtask

  initial begin
    int n;
    logic [7:0] rop, rimm;
    for (int i = 0; i < DEPTH; i++) tb_mem[i] = 16'h0000;
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    check_reset_outputs("reset");

    // Zero-latency program: cycle-exact timing of out_valid and halted.
    load_prog1(); lat = 0;
    model_run(20);
    do_start();
    for (int k = 1; k <= 10; k++) begin
      chk($sformatf("t1_out_valid_c%0d", k), 32'(out_valid), 32'(k == 7));
      chk($sformatf("t1_halted_c%0d", k), 32'(halted), 32'(k >= 9));
      step();
    end
    chk("t1_out", 32'(out), 32'h0008);
    chk("t1_err", 32'(err), 32'(m_err));
    chk("t1_pc", 32'(pc), 32'(m_pc));
    chk("t1_drained", 32'(exp_fetch.size() + exp_out.size()), 32'd0);

    // Same program, 3-cycle memory latency.
    do_reset(); lat = 3;
    model_run(20);
    do_start();
    wait_halt(200);
    chk("t2_out", 32'(out), 32'h0008);
    chk("t2_err", 32'(err), 32'd0);
    chk("t2_drained", 32'(exp_fetch.size() + exp_out.size()), 32'd0);

    // Start pulsed during EXEC must be ignored.
    do_reset(); lat = 0;
    model_run(20);
    do_start();
    step();
    chk("t3_in_exec", 32'(busy && !mem_req), 32'd1);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("t3_pc_after_busy_start", 32'(pc), 32'd1);
    wait_halt(100);
    chk("t3_pc", 32'(pc), 32'(m_pc));
    chk("t3_drained", 32'(exp_fetch.size() + exp_out.size()), 32'd0);

    // Reset while a fetch is being answered; late rvalid must be ignored.
    allow_extra = 1;
    do_start();
    chk("t4_fetching", 32'(mem_req), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    force_rv = 1;
    check_reset_outputs("t4_rst");
    step(); step();
    force_rv = 0;
    chk("t4_late_busy", 32'(busy), 32'd0);
    chk("t4_late_pc", 32'(pc), 32'd0);
    chk("t4_late_out_valid", 32'(out_valid), 32'd0);
    allow_extra = 0;

    // Fetch timeout.
    do_reset(); no_resp = 1;
    do_start();
    n = 0;
    while (mem_req && n < 100) begin n++; step(); end
    chk("t5_wait_cycles", 32'(n), 32'd15);
    chk("t5_err", 32'(err), 32'd1);
    chk("t5_halted", 32'(halted), 32'd1);
    chk("t5_mem_req", 32'(mem_req), 32'd0);
    no_resp = 0;

    // Illegal opcode, then a restart clears err.
    do_reset();
    tb_mem[0] = 16'h7712;
    model_run(5);
    do_start();
    wait_halt(50);
    chk("t6_err", 32'(err), 32'(m_err));
    chk("t6_pc", 32'(pc), 32'(m_pc));
    chk("t6_out", 32'(out), 32'd0);
    tb_mem[0] = 16'h0107; tb_mem[1] = 16'hFF00;
    model_run(5);
    do_start();
    chk("t6_err_cleared", 32'(err), 32'd0);
    chk("t6_restart_pc", 32'(pc), 32'd0);
    wait_halt(50);
    chk("t6_out_after", 32'(out), 32'h0007);
    chk("t6_drained", 32'(exp_fetch.size() + exp_out.size()), 32'd0);

    // Accumulator wrap, JZ, PC wrap and rerun, random memory latency.
    do_reset(); rand_lat = 1; allow_extra = 1;
    for (int i = 0; i < DEPTH; i++) tb_mem[i] = 16'h0000;
    tb_mem[0] = 16'h02FF; tb_mem[1] = 16'h0301; tb_mem[2] = 16'h0604;
    tb_mem[3] = 16'h0500; tb_mem[4] = 16'h0107;
    model_run(70);
    do_start();
    wait_drain(800);
    step(); step();
    chk("t7_out_drained", 32'(exp_out.size()), 32'd0);
    chk("t7_err", 32'(err), 32'd0);
    allow_extra = 0;

    // Random programs.
    for (int r = 0; r < 6; r++) begin
      do_reset();
      for (int i = 0; i < DEPTH; i++) begin
        n = int'($urandom_range(0, 11));
        rop = (n <= 6) ? 8'(n) : ((n <= 9) ? 8'hFF : 8'h42);
        rimm = 8'($urandom_range(0, 255));
        tb_mem[i] = {rop, rimm};
      end
      model_run(40);
      allow_extra = !m_done;
      do_start();
      if (m_done) begin
        wait_halt(400);
        chk("rand_err", 32'(err), 32'(m_err));
        chk("rand_pc", 32'(pc), 32'(m_pc));
        chk("rand_drained", 32'(exp_fetch.size() + exp_out.size()), 32'd0);
      end else begin
        wait_drain(400);
        step(); step();
        chk("rand_out_drained", 32'(exp_out.size()), 32'd0);
      end
      allow_extra = 0;
    end
    do_reset();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
